// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmit FSM state codes and the
// bit-period helper used by both the TX and RX sides.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;
    localparam uart_state_t ST_BREAK  = 3'd5;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 while enabled, held at 0 otherwise,
// and flags the last clock of every bit period.
module uart_baud_tick #(
    parameter int DIV = 434,
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stop bits.
// Line-break generation (tx_break port, BREAK state) is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int BREAK_BITS = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_done
`ifdef UART_TX_BREAK_EN
    ,
    input  logic                 tx_break
`endif
);

    localparam int         DIV       = calc_div(CLK_FREQ, BAUD);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (DIV < 4) begin : g_bad_div
        $error("uart_tx_frame: CLK_FREQ/BAUD must give at least 4 clocks per bit");
    end
    if (BREAK_BITS < 1) begin : g_bad_break_bits
        $error("uart_tx_frame: BREAK_BITS must be at least 1");
    end

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 no_done_q, no_done_d;   // current frame is a break: suppress tx_done
    logic                 tick, baud_en, brk_req, brk_exit;

`ifdef UART_TX_BREAK_EN
    localparam int            BW       = (BREAK_BITS > 1) ? $clog2(BREAK_BITS + 1) : 1;
    localparam logic [BW-1:0] BRK_LAST = BW'(BREAK_BITS - 1);

    logic [BW-1:0] brk_cnt_q, brk_cnt_d;
    logic          brk_min_q, brk_min_d;

    always_comb begin
        brk_cnt_d = brk_cnt_q;
        brk_min_d = brk_min_q;
        if (state_q != ST_BREAK) begin
            brk_cnt_d = '0;
            brk_min_d = 1'b0;
        end else if (tick) begin
            if (brk_cnt_q == BRK_LAST) brk_min_d = 1'b1;
            else                       brk_cnt_d = brk_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brk_cnt_q <= '0;
            brk_min_q <= 1'b0;
        end else begin
            brk_cnt_q <= brk_cnt_d;
            brk_min_q <= brk_min_d;
        end
    end

    // Leave as soon as the minimum length is met and the request has dropped.
    assign brk_req  = tx_break;
    assign brk_exit = (state_q == ST_BREAK) && !tx_break &&
                      (brk_min_q || (tick && brk_cnt_q == BRK_LAST));
`else
    assign brk_req  = 1'b0;
    assign brk_exit = 1'b0;
`endif

    // Dropping enable on break exit restarts the bit timer for the stop bits.
    assign baud_en  = (state_q != ST_IDLE) && !brk_exit;
    assign tx_ready = (state_q == ST_IDLE) && !brk_req;
    assign tx       = tx_q;
    assign tx_done  = done_q;

    uart_baud_tick #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .en_i  (baud_en),
        .tick_o(tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        no_done_d = no_done_q;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (brk_req) begin
                    state_d   = ST_BREAK;
                    tx_d      = 1'b0;
                    no_done_d = 1'b1;
                end else if (tx_valid) begin
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    shift_d   = tx_data;
                    parity_d  = (PARITY == PARITY_ODD) ? ~^tx_data : ^tx_data;
                    no_done_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                        done_d    = !no_done_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_BREAK: begin
                if (brk_exit) begin
                    state_d   = ST_STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            no_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            no_done_q <= no_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1 DIV=434, 8O1, 8E1, 7N2 at DIV=8),
// table vectors, back-to-back, mid-frame reset, random frames; break test with UART_TX_BREAK_EN.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] valid_v = '0;
    logic [8:0] data_v [4];
    wire  [3:0] ready_v;
    wire  [3:0] tx_v;
    wire  [3:0] done_v;
`ifdef UART_TX_BREAK_EN
    logic [3:0] brk_v = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame u0 (
        .clk(clk), .rst(rst), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]),
        .tx_data(data_v[0][7:0]), .tx(tx_v[0]), .tx_done(done_v[0])
`ifdef UART_TX_BREAK_EN
        , .tx_break(brk_v[0])
`endif
    );
    uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(125_000), .PARITY(1)) u1 (
        .clk(clk), .rst(rst), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]),
        .tx_data(data_v[1][7:0]), .tx(tx_v[1]), .tx_done(done_v[1])
`ifdef UART_TX_BREAK_EN
        , .tx_break(brk_v[1])
`endif
    );
    uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(125_000), .PARITY(2)) u2 (
        .clk(clk), .rst(rst), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]),
        .tx_data(data_v[2][7:0]), .tx(tx_v[2]), .tx_done(done_v[2])
`ifdef UART_TX_BREAK_EN
        , .tx_break(brk_v[2])
`endif
    );
    uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(125_000), .DATA_BITS(7), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .tx_valid(valid_v[3]), .tx_ready(ready_v[3]),
        .tx_data(data_v[3][6:0]), .tx(tx_v[3]), .tx_done(done_v[3])
`ifdef UART_TX_BREAK_EN
        , .tx_break(brk_v[3])
`endif
    );

    function automatic int cfg_div(input int k);
        return (k == 0) ? 434 : 8;
    endfunction
    function automatic int cfg_bits(input int k);
        return (k == 3) ? 7 : 8;
    endfunction
    function automatic int cfg_par(input int k);
        return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
    endfunction
    function automatic int cfg_stop(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    // Reference: list of line levels, one per bit time, in transmission order.
    task automatic model_frame(input int k, input logic [8:0] d, output logic [15:0] v, output int len);
        int ones = 0;
        v   = '0;
        len = 1;                                   // start bit is 0
        for (int i = 0; i < cfg_bits(k); i++) begin
            v[len] = d[i];
            ones  += int'(d[i]);
            len++;
        end
        if (cfg_par(k) == 1) begin v[len] = (ones % 2 == 0); len++; end
        if (cfg_par(k) == 2) begin v[len] = (ones % 2 == 1); len++; end
        for (int i = 0; i < cfg_stop(k); i++) begin v[len] = 1'b1; len++; end
    endtask

    // Wait (bounded) for tx_ready, then present a word for one accepting edge.
    task automatic send(input int k, input logic [8:0] d);
        int w = 0;
        while (ready_v[k] !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (ready_v[k] !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait k=%0d tx_ready=%b expected=1", k, ready_v[k]);
        end
        data_v[k]  = d;
        valid_v[k] = 1'b1;
        @(posedge clk); #1;
    endtask

    // Called at the first sample after the accepting edge; returns at the tx_done sample.
    task automatic check_frame(input int k, input logic [15:0] ev, input int len, input bit scramble);
        int div = cfg_div(k);
        for (int b = 0; b < len; b++) begin
            bit   bad = 1'b0;
            logic gt = 1'b0, gd = 1'b0, gr = 1'b0;
            for (int c = 0; c < div; c++) begin
                if (!bad && (tx_v[k] !== ev[b] || done_v[k] !== 1'b0 || ready_v[k] !== 1'b0)) begin
                    bad = 1'b1;
                    gt  = tx_v[k];
                    gd  = done_v[k];
                    gr  = ready_v[k];
                end
                if (scramble) data_v[k] = 9'($urandom);
                @(posedge clk); #1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL frame_bit k=%0d bit=%0d tx=%b done=%b ready=%b expected tx=%b done=0 ready=0",
                         k, b, gt, gd, gr, ev[b]);
            end
        end
        checks++;
        if (done_v[k] !== 1'b1 || ready_v[k] !== 1'b1 || tx_v[k] !== 1'b1) begin
            errors++;
            $display("FAIL frame_end k=%0d done=%b ready=%b tx=%b expected done=1 ready=1 tx=1",
                     k, done_v[k], ready_v[k], tx_v[k]);
        end
    endtask

    typedef struct {
        int          k;
        logic [8:0]  data;
        logic [15:0] ev;
        int          len;
    } vec_t;

    vec_t        tbl [4];
    logic [15:0] ev;
    int          len, rk, chain, gap;
    logic [8:0]  rd, nd;
    bit          more, bad;

    initial begin
        // Hand-derived line sequences, bit 0 = start bit.
        tbl[0] = '{0, 9'h055, 16'h02AA, 10};   // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
        tbl[1] = '{1, 9'h007, 16'h040E, 11};   // odd parity of 0x07 -> 0
        tbl[2] = '{2, 9'h007, 16'h060E, 11};   // even parity of 0x07 -> 1
        tbl[3] = '{3, 9'h0FF, 16'h03FE, 10};   // 7 data ones + 2 stop bits
        for (int k = 0; k < 4; k++) data_v[k] = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tx_v[k] !== 1'b1 || ready_v[k] !== 1'b1 || done_v[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state k=%0d tx=%b ready=%b done=%b expected 1 1 0",
                         k, tx_v[k], ready_v[k], done_v[k]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            send(tbl[i].k, tbl[i].data);
            valid_v[tbl[i].k] = 1'b0;
            check_frame(tbl[i].k, tbl[i].ev, tbl[i].len, 1'b1);
            @(posedge clk); #1;
        end

        // Back-to-back with tx_valid held: one idle-high clock between frames.
        send(0, 9'h0A5);
        data_v[0] = 9'h03C;
        model_frame(0, 9'h0A5, ev, len);
        check_frame(0, ev, len, 1'b0);
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        model_frame(0, 9'h03C, ev, len);
        check_frame(0, ev, len, 1'b1);
        @(posedge clk); #1;

        // Reset during data bit 3 of 0xC3 (bit 3 = 0).
        send(0, 9'h0C3);
        valid_v[0] = 1'b0;
        repeat (4 * 434 + 200) begin @(posedge clk); #1; end
        checks++;
        if (tx_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_bit3 tx=%b expected=0", tx_v[0]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (tx_v[0] !== 1'b1 || ready_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset tx=%b ready=%b done=%b expected 1 1 0", tx_v[0], ready_v[0], done_v[0]);
        end
        bad = 1'b0;
        repeat (4400) begin
            @(posedge clk); #1;
            if (tx_v[0] !== 1'b1 || done_v[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL post_reset_idle line left idle-high/no-done state, expected tx=1 done=0 throughout");
        end
        send(0, 9'h05A);
        valid_v[0] = 1'b0;
        model_frame(0, 9'h05A, ev, len);
        check_frame(0, ev, len, 1'b1);
        @(posedge clk); #1;

        // Random frames and back-to-back chains on the short-DIV instances.
        for (int n = 0; n < 50; n++) begin
            rk    = 1 + int'($urandom_range(0, 2));
            rd    = 9'($urandom);
            chain = 1 + int'($urandom_range(0, 2));
            send(rk, rd);
            for (int j = 0; j < chain; j++) begin
                more = (j < chain - 1);
                nd   = 9'($urandom);
                if (more) data_v[rk] = nd;
                else      valid_v[rk] = 1'b0;
                model_frame(rk, rd, ev, len);
                check_frame(rk, ev, len, !more);
                if (more) begin
                    @(posedge clk); #1;
                    rd = nd;
                end
            end
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin @(posedge clk); #1; end
        end

`ifdef UART_TX_BREAK_EN
        // One-clock break request: 11 bit times low, one stop bit high, no tx_done.
        @(posedge clk); #1;
        brk_v[0] = 1'b1;
        @(posedge clk); #1;
        brk_v[0] = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 11 * 434; c++) begin
            if (tx_v[0] !== 1'b0 || ready_v[0] !== 1'b0 || done_v[0] !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL break_low expected tx=0 ready=0 done=0 for 4774 clk"); end
        bad = 1'b0;
        for (int c = 0; c < 434; c++) begin
            if (tx_v[0] !== 1'b1 || ready_v[0] !== 1'b0 || done_v[0] !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL break_stop expected tx=1 ready=0 done=0 for 434 clk"); end
        checks++;
        if (ready_v[0] !== 1'b1 || done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL break_end ready=%b done=%b tx=%b expected 1 0 1", ready_v[0], done_v[0], tx_v[0]);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL timeout simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
